bram_port_arbiter: RTL

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter
//  Purpose  : Shares one single-port BRAM between two requesters
//             (0 = SPI-side FSM, 1 = user application). Grants are
//             combinational, round-robin on contention, with an optional
//             burst lock. Read returns are tagged through an RD_LAT-deep
//             pipeline so each requester sees its own rvalid.
//  Build    : define BRAM_ARB_LOCK_EN to enable burst locking (lock0/lock1,
//             OWN0/OWN1 states, MAX_LOCK counter). Undefined = pure
//             round-robin, lock inputs ignored.
//  Ports    : clk, rstb (async active-low)
//             req/we/lock/addr/wdata {0,1} -> requester inputs
//             gnt{0,1}, rvalid{0,1}, rdata  -> requester outputs
//             bram_en/we/addr/di, bram_do   -> BRAM port
//             busy                          -> a read is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_do,
    output logic              busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_own0 = 2'd1;
    localparam logic [1:0] c_st_own1 = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_last;        // 1 = requester 1 won most recently
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_we_sel;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_di_sel;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_di_hold;
    logic [RD_LAT-1:0] r_tag_vld;     // stage i: a read issued i+1 cycles ago
    logic [RD_LAT-1:0] r_tag_id;      // requester that owns that read

`ifdef BRAM_ARB_LOCK_EN
    localparam int                 c_cnt_w    = $clog2(MAX_LOCK + 1);
    localparam logic [c_cnt_w-1:0] c_max_lock = c_cnt_w'(MAX_LOCK);

    logic [c_cnt_w-1:0] r_lock_cnt;   // grants taken in the current lock run
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_cnt_done;

    assign w_cnt_inc  = r_lock_cnt + 1'b1;
    assign w_cnt_done = (w_cnt_inc >= c_max_lock);

    // Entering a lock counts as the first grant of the run.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_lock_cnt <= '0;
        end else if (w_state_next == c_st_idle) begin
            r_lock_cnt <= '0;
        end else if (r_state == c_st_idle) begin
            r_lock_cnt <= c_cnt_w'(1);
        end else begin
            r_lock_cnt <= w_cnt_inc;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^{lock0, lock1};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = c_st_idle;
`ifdef BRAM_ARB_LOCK_EN
        case (r_state)
            c_st_idle: begin
                if (w_gnt0 && lock0) begin
                    w_state_next = c_st_own0;
                end else if (w_gnt1 && lock1) begin
                    w_state_next = c_st_own1;
                end
            end
            c_st_own0: begin
                if (req0 && lock0 && !w_cnt_done) begin
                    w_state_next = c_st_own0;
                end
            end
            c_st_own1: begin
                if (req1 && lock1 && !w_cnt_done) begin
                    w_state_next = c_st_own1;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
`endif
    end

    // ---------------- FSM: grant outputs ----------------
    // Grants are forced low while reset is asserted so the BRAM sees no
    // access during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rstb) begin
            case (r_state)
                c_st_own0: w_gnt0 = req0;
                c_st_own1: w_gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign w_any_gnt  = w_gnt0 | w_gnt1;
    assign w_we_sel   = w_gnt1 ? we1    : we0;
    assign w_addr_sel = w_gnt1 ? addr1  : addr0;
    assign w_di_sel   = w_gnt1 ? wdata1 : wdata0;
    assign w_rd_issue = w_any_gnt & ~w_we_sel;

    assign bram_en    = w_any_gnt;
    assign bram_we    = w_any_gnt & w_we_sel;
    assign bram_addr  = w_any_gnt ? w_addr_sel : r_addr_hold;
    assign bram_di    = w_any_gnt ? w_di_sel   : r_di_hold;
    assign rdata      = rstb ? bram_do : '0;

    // Last-winner pointer and held address/data for idle cycles.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_last      <= 1'b1;
            r_addr_hold <= '0;
            r_di_hold   <= '0;
        end else if (w_any_gnt) begin
            r_last      <= w_gnt1;
            r_addr_hold <= w_addr_sel;
            r_di_hold   <= w_di_sel;
        end
    end

    // ---------------- read tag pipeline ----------------
    generate
        if (RD_LAT == 1) begin : g_tag_lat1
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_tag_vld <= '0;
                    r_tag_id  <= '0;
                end else begin
                    r_tag_vld <= w_rd_issue;
                    r_tag_id  <= w_gnt1;
                end
            end
        end else begin : g_tag_latn
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_tag_vld <= '0;
                    r_tag_id  <= '0;
                end else begin
                    r_tag_vld <= {r_tag_vld[RD_LAT-2:0], w_rd_issue};
                    r_tag_id  <= {r_tag_id[RD_LAT-2:0],  w_gnt1};
                end
            end
        end
    endgenerate

    assign rvalid0 = r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
    assign rvalid1 = r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];
    assign busy    = |r_tag_vld;

endmodule
`default_nettype wire
